// File: rtl/tv80_alu16_seq.sv
// tv80_alu16_seq: two-pass (low byte, high byte) 16-bit ADD/ADC/SBC around the TV80 8-bit ALU.
// Define TV80_ALU16_INC16_EN to run op=11 as INC16; otherwise op=11 runs as ADD16.
module tv80_alu16_seq #(
  parameter int Flag_C = 0,
  parameter int Flag_Z = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [7:0]  f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  f_out,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_busa,
  output logic [7:0]  alu_busb,
  output logic [7:0]  alu_f_in,
  output logic        alu_arith16,
  output logic        alu_z16,
  input  logic [7:0]  alu_q,
  input  logic [7:0]  alu_f_out
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_ADC, OP_SBC, OP_INC} op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [7:0]  f_q, f_d;
  logic [7:0]  lo_f_q, lo_f_d;
  logic [7:0]  lo_r_q, lo_r_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  f_out_q, f_out_d;
  logic        done_q, done_d;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    f_d      = f_q;
    lo_f_d   = lo_f_q;
    lo_r_d   = lo_r_q;
    result_d = result_q;
    f_out_d  = f_out_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
`ifdef TV80_ALU16_INC16_EN
          op_d = op_t'(op);
`else
          op_d = (op == 2'b11) ? OP_ADD : op_t'(op);
`endif
          opa_d   = opa;
          opb_d   = opb;
          f_d     = f_in;
          state_d = S_LO;
        end
      end
      S_LO: begin
        lo_r_d  = alu_q;
        lo_f_d  = alu_f_out;
        state_d = S_HI;
      end
      S_HI: begin
        // result only changes here, so it holds through LO of the next op
        result_d = {alu_q, lo_r_q};
        f_out_d  = alu_f_out;
`ifdef TV80_ALU16_INC16_EN
        if (op_q == OP_INC) f_out_d = f_q;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_op      = 4'b0000;
    alu_busa    = '0;
    alu_busb    = '0;
    alu_f_in    = '0;
    alu_arith16 = 1'b0;
    alu_z16     = 1'b0;
    unique case (state_q)
      S_LO: begin
        alu_busa    = opa_q[7:0];
        alu_busb    = opb_q[7:0];
        alu_f_in    = f_q;
        alu_op      = (op_q == OP_SBC) ? 4'b0011 :
                      (op_q == OP_ADC) ? 4'b0001 : 4'b0000;
        alu_arith16 = (op_q == OP_ADD) || (op_q == OP_INC);
      end
      S_HI: begin
        alu_busa    = opa_q[15:8];
        alu_busb    = opb_q[15:8];
        alu_f_in    = lo_f_q;
        alu_op      = (op_q == OP_SBC) ? 4'b0011 : 4'b0001;
        alu_arith16 = (op_q == OP_ADD) || (op_q == OP_INC);
        alu_z16     = (op_q == OP_ADC) || (op_q == OP_SBC);
      end
      default: ;
    endcase
`ifdef TV80_ALU16_INC16_EN
    if (op_q == OP_INC && state_q == S_LO) alu_busb = 8'h01;
    if (op_q == OP_INC && state_q == S_HI) alu_busb = 8'h00;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      opa_q    <= '0;
      opb_q    <= '0;
      f_q      <= '0;
      lo_f_q   <= '0;
      lo_r_q   <= '0;
      result_q <= '0;
      f_out_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      f_q      <= f_d;
      lo_f_q   <= lo_f_d;
      lo_r_q   <= lo_r_d;
      result_q <= result_d;
      f_out_q  <= f_out_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign f_out  = f_out_q;

  // Sanity of the attached ALU: 17-bit carry/borrow and 16-bit zero
  add_chk: assert property (@(posedge clk) disable iff (reset)
    (state_q == S_DONE && (op_q == OP_ADD || op_q == OP_ADC)) |->
      ({f_out_q[Flag_C], result_q} ==
       {1'b0, opa_q} + {1'b0, opb_q} + 17'(op_q == OP_ADC && f_q[Flag_C])));

  sbc_chk: assert property (@(posedge clk) disable iff (reset)
    (state_q == S_DONE && op_q == OP_SBC) |->
      ({f_out_q[Flag_C], result_q} ==
       {1'b0, opa_q} - {1'b0, opb_q} - 17'(f_q[Flag_C])));

  z_chk: assert property (@(posedge clk) disable iff (reset)
    (state_q == S_DONE && (op_q == OP_ADC || op_q == OP_SBC)) |->
      (f_out_q[Flag_Z] == (result_q == 16'h0000)));

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// tb_tv80_alu16_seq: TV80 ALU stand-in, vector table, random ops vs a 16-bit model,
// and handshake/reset sequences for tv80_alu16_seq.
module tb_tv80_alu16_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [15:0] opa, opb;
  logic [7:0]  f_in;
  logic        busy, done;
  logic [15:0] result;
  logic [7:0]  f_out;
  logic [3:0]  alu_op;
  logic [7:0]  alu_busa, alu_busb, alu_f_in;
  logic        alu_arith16, alu_z16;
  logic [7:0]  alu_q, alu_f_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tv80_alu16_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .opa(opa), .opb(opb), .f_in(f_in),
    .busy(busy), .done(done), .result(result), .f_out(f_out),
    .alu_op(alu_op), .alu_busa(alu_busa), .alu_busb(alu_busb),
    .alu_f_in(alu_f_in), .alu_arith16(alu_arith16), .alu_z16(alu_z16),
    .alu_q(alu_q), .alu_f_out(alu_f_out)
  );

  // Behavioural TV80 ALU for ops 0000 ADD, 0001 ADC, 0010 SUB, 0011 SBC
  int         a_cin, a_sum, a_half, a_sgn;
  logic       a_sub;
  logic [7:0] a_q, a_f;
  always_comb begin
    a_sub  = alu_op[1];
    a_cin  = (alu_op[0] && alu_f_in[0]) ? 1 : 0;
    a_sum  = 0;
    a_half = 0;
    a_sgn  = 0;
    if (a_sub) begin
      a_sum  = int'(alu_busa) - int'(alu_busb) - a_cin;
      a_half = int'(alu_busa[3:0]) - int'(alu_busb[3:0]) - a_cin;
      a_sgn  = int'($signed(alu_busa)) - int'($signed(alu_busb)) - a_cin;
    end else begin
      a_sum  = int'(alu_busa) + int'(alu_busb) + a_cin;
      a_half = int'(alu_busa[3:0]) + int'(alu_busb[3:0]) + a_cin;
      a_sgn  = int'($signed(alu_busa)) + int'($signed(alu_busb)) + a_cin;
    end
    a_q    = a_sum[7:0];
    a_f    = alu_f_in;
    a_f[0] = a_sub ? (a_sum < 0) : (a_sum > 255);
    a_f[1] = a_sub;
    a_f[2] = (a_sgn > 127) || (a_sgn < -128);
    a_f[3] = a_q[3];
    a_f[4] = a_sub ? (a_half < 0) : (a_half > 15);
    a_f[5] = a_q[5];
    a_f[6] = (a_q == 8'h00) ? (alu_z16 ? alu_f_in[6] : 1'b1) : 1'b0;
    a_f[7] = a_q[7];
    if (alu_arith16) begin
      a_f[7] = alu_f_in[7];
      a_f[6] = alu_f_in[6];
      a_f[2] = alu_f_in[2];
    end
    alu_q     = a_q;
    alu_f_out = a_f;
  end

  // 16-bit reference: {result, flags}
  function automatic logic [23:0] ref16(input logic [1:0] o,
                                        input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic [7:0] f);
    int c, sum, half, sgn;
    logic [15:0] res;
    logic [7:0]  fo;
    c  = int'(f[0]);
    fo = f;
`ifdef TV80_ALU16_INC16_EN
    if (o == 2'b11) begin
      res = a + 16'h0001;
      return {res, f};
    end
`endif
    if (o == 2'b10) begin
      sum  = int'(a) - int'(b) - c;
      half = int'(a[11:0]) - int'(b[11:0]) - c;
      sgn  = int'($signed(a)) - int'($signed(b)) - c;
    end else begin
      if (o != 2'b01) c = 0;
      sum  = int'(a) + int'(b) + c;
      half = int'(a[11:0]) + int'(b[11:0]) + c;
      sgn  = int'($signed(a)) + int'($signed(b)) + c;
    end
    res   = sum[15:0];
    fo[0] = (o == 2'b10) ? (sum < 0) : (sum > 65535);
    fo[1] = (o == 2'b10);
    fo[3] = res[11];
    fo[4] = (o == 2'b10) ? (half < 0) : (half > 4095);
    fo[5] = res[13];
    if (o == 2'b01 || o == 2'b10) begin
      fo[7] = res[15];
      fo[6] = (res == 16'h0000);
      fo[2] = (sgn > 32767) || (sgn < -32768);
    end
    return {res, fo};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] f, output logic [15:0] r,
                        output logic [7:0] fo, output int lat);
    logic [15:0] prev;
    prev = result;
    op = o; opa = a; opb = b; f_in = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_hold"}, 32'(result), 32'(prev));
    op   = 2'($urandom);
    opa  = 16'($urandom);
    opb  = 16'($urandom);
    f_in = 8'($urandom);
    while (!done && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    r  = result;
    fo = f_out;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [7:0]  f;
    logic [15:0] er;
    logic [7:0]  ef;
  } vec_t;

  vec_t        tbl[6];
  logic [15:0] r;
  logic [7:0]  fo;
  logic [23:0] e;
  int          lat, ndone;
  logic [1:0]  ro;
  logic [15:0] ra, rb;
  logic [7:0]  rf;

  initial begin
    tbl[0] = '{2'b00, 16'h1234, 16'h0FFF, 8'hC4, 16'h2233, 8'hF4};
    tbl[1] = '{2'b01, 16'hFFFF, 16'h0000, 8'h01, 16'h0000, 8'h51};
    tbl[2] = '{2'b10, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 8'h3E};
    tbl[3] = '{2'b10, 16'h0100, 16'h0100, 8'h00, 16'h0000, 8'h42};
    tbl[4] = '{2'b01, 16'h0100, 16'h0000, 8'h00, 16'h0100, 8'h00};
`ifdef TV80_ALU16_INC16_EN
    tbl[5] = '{2'b11, 16'hFFFF, 16'h1234, 8'hA5, 16'h0000, 8'hA5};
`else
    tbl[5] = '{2'b11, 16'hFFFF, 16'h1234, 8'hA5, 16'h1233, 8'h95};
`endif

    reset = 1'b1; start = 1'b0; op = '0;
    opa = '0; opb = '0; f_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_fout", 32'(f_out), 32'd0);
    chk("rst_aluop", 32'({alu_op, alu_busa, alu_busb}), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].f, r, fo, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_res", i), 32'(r), 32'(tbl[i].er));
      chk($sformatf("vec%0d_flags", i), 32'(fo), 32'(tbl[i].ef));
    end

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rf = 8'($urandom);
      if (i < 4) rb = (i[0]) ? ra : 16'h0000;
      e = ref16(ro, ra, rb, rf);
      run_op($sformatf("rnd%0d", i), ro, ra, rb, rf, r, fo, lat);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd4);
      chk($sformatf("rnd%0d_res", i), 32'(r), 32'(e[23:8]));
      chk($sformatf("rnd%0d_flags", i), 32'(fo), 32'(e[7:0]));
    end

    // start held high through LO and HI with different operands
    e = ref16(2'b00, 16'h4321, 16'h1111, 8'h00);
    op = 2'b00; opa = 16'h4321; opb = 16'h1111; f_in = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    op = 2'b10; opa = 16'hFFFF; opb = 16'h0001; f_in = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; r = '0; fo = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        r  = result;
        fo = f_out;
      end
    end
    chk("repulse_ndone", 32'(ndone), 32'd1);
    chk("repulse_res", 32'(r), 32'(e[23:8]));
    chk("repulse_flags", 32'(fo), 32'(e[7:0]));

    // reset asserted while in HI
    op = 2'b00; opa = 16'h7000; opb = 16'h0123; f_in = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy_hi", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_fout", 32'(f_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midrst_nodone", 32'(ndone), 32'd0);

    e = ref16(2'b00, 16'hABCD, 16'h1234, 8'h44);
    run_op("post", 2'b00, 16'hABCD, 16'h1234, 8'h44, r, fo, lat);
    chk("post_lat", 32'(lat), 32'd4);
    chk("post_res", 32'(r), 32'(e[23:8]));
    chk("post_flags", 32'(fo), 32'(e[7:0]));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tv80_alu16_seq.md
Name: tv80_alu16_seq

Overview:
- Two-pass 16-bit arithmetic sequencer that sits directly around the 8-bit ALU.
- Drives the ALU operand, opcode and flag inputs, and captures its Q and F_Out outputs.
- Runs low byte then high byte to execute ADD HL,rr / ADC HL,rr / SBC HL,rr.
- Returns a 16-bit result and final flags to the core with a start/done handshake.

Parameters:
- Flag_C, 0, bit index of carry in F.
- Flag_Z, 6, bit index of zero in F.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  00 ADD16, 01 ADC16, 10 SBC16, 11 see Optional Feature.
- opa  in  16  operand A (HL).
- opb  in  16  operand B (rr).
- f_in  in  8  flags at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result and f_out are valid in this cycle.
- result  out  16  registered 16-bit result.
- f_out  out  8  registered final flags.
- alu_op  out  4  to ALU ALU_Op.
- alu_busa  out  8  to ALU BusA.
- alu_busb  out  8  to ALU BusB.
- alu_f_in  out  8  to ALU F_In.
- alu_arith16  out  1  to ALU Arith16.
- alu_z16  out  1  to ALU Z16.
- alu_q  in  8  from ALU Q.
- alu_f_out  in  8  from ALU F_Out.

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0, f_out=0. Internal operand and flag registers = 0.
- FSM: IDLE -> LO -> HI -> DONE -> IDLE.
  - IDLE: start=1 latches op, opa, opb and f_in, then moves to LO.
  - LO and HI each take exactly one cycle.
  - DONE asserts done for one cycle, then returns to IDLE.
- Latency: start sampled at edge N; done=1 during the cycle after edge N+3. No back-to-back overlap.
- The ALU is combinational. alu_* outputs are decoded from state and registers only, never from ports.
- In IDLE and DONE: alu_op=0, busa=busb=0, alu_f_in=0, arith16=0, z16=0.
- LO pass:
  - busa=opa[7:0], busb=opb[7:0], alu_f_in = latched f_in.
  - alu_op: 0000 for ADD16, 0001 for ADC16, 0011 for SBC16.
  - arith16=1 for ADD16, else 0. z16=0.
  - Edge captures result[7:0]=alu_q and an internal flag register = alu_f_out.
- HI pass:
  - busa=opa[15:8], busb=opb[15:8], alu_f_in = LO-captured flags, so carry and Z chain through.
  - alu_op: 0001 for ADD16 and ADC16, 0011 for SBC16.
  - arith16 as in LO. z16=1 for ADC16 and SBC16, else 0.
  - Edge captures result[15:8]=alu_q and f_out=alu_f_out.
- Resulting flag semantics:
  - ADD16 keeps S, Z, P from f_in. C, H, N, X, Y come from the high byte.
  - ADC16/SBC16: Z=1 only if both bytes are zero. S, P/V, H, C come from the high byte.
- start while busy or in DONE: ignored, no queueing.
- Reset asserted mid-operation: returns to IDLE immediately. No done is produced and result/f_out are cleared.
- result and f_out hold their values after done until the next accepted start completes HI.

Optional Feature:
- Macro: TV80_ALU16_INC16_EN.
- Defined, op=11 is INC16:
  - LO uses busb=0x01 with alu_op 0000; HI uses busb=0x00 with alu_op 0001; arith16=1.
  - result = opa+1 mod 65536.
  - f_out = latched f_in unchanged (ALU flags discarded), per Z80 INC rr.
- Undefined: op=11 executes exactly as ADD16. No INC16 logic is present.

Test Plan:
- ADD16 opa=0x1234, opb=0x0FFF, f_in=0xC4 -> done 4 cycles after start; result=0x2233, f_out=0xF4.
- ADC16 opa=0xFFFF, opb=0x0000, f_in=0x01 -> result=0x0000, f_out=0x51 (Z, H, C set).
- SBC16 opa=0x8000, opb=0x0001, f_in=0x00 -> result=0x7FFF, f_out=0x3E (V, N, H set).
- Z chaining:
  - SBC16 0x0100-0x0100, f_in=0x00 -> result 0x0000, Z=1.
  - ADC16 0x0100+0x0000, f_in=0x00 -> result 0x0100, Z=0 despite a zero low byte.
- Handshake and reset:
  - start re-pulsed during LO and HI -> ignored, exactly one done.
  - reset asserted during HI -> busy=0, done never pulses, result=0.
  - A following ADD16 completes normally.
- With TV80_ALU16_INC16_EN: op=11, opa=0xFFFF, f_in=0xA5 -> result=0x0000, f_out=0xA5.
- Without it: the same stimulus gives ADD16 behaviour, opa+opb.
